// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg: slot record and refill-ID mapping shared by the L0 MSHR.
// Slot fields are sized for the widest supported configuration (up to 256
// lines, tags up to 64 bits); users zero-extend into them and compare at
// full width.
package snitch_icache_pkg;
  localparam int unsigned SlotLineW = 8;
  localparam int unsigned SlotTagW  = 64;
  typedef struct packed {
    logic                 busy;
    logic                 stale;
    logic [SlotLineW-1:0] line;
    logic [SlotTagW-1:0]  tag;
  } slot_t;
  function automatic int unsigned slot_id(input int unsigned l0_id, input int unsigned nr_pending,
                                          input int unsigned slot);
    return l0_id * nr_pending + slot;
  endfunction
endpackage

// File: rtl/lzc.sv
// lzc: leading/trailing zero counter, interface-compatible with common_cells.
// Ports: in_i vector, cnt_o zero count (MODE=0 trailing, MODE=1 leading),
// empty_o when in_i is all zero.
module lzc #(
  parameter int unsigned WIDTH     = 2,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (in_i[MODE ? WIDTH - 1 - i : i]) cnt_o = CNT_WIDTH'(i);
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/snitch_icache_l0_mshr_slots.sv
// snitch_icache_l0_mshr_slots: MSHR slot table with refill-ID decode.
// Ports: flush_i marks busy slots stale; alloc_i claims the lowest free slot
// (free_idx_o) for alloc_line_i/alloc_tag_i; rsp_valid_i/rsp_id_i decode a
// response to a busy slot (rsp_hit_o, rsp_stale_o, rsp_line_o) and free it;
// slots_o exposes the table, free_o/two_free_o report free capacity.
module snitch_icache_l0_mshr_slots
  import snitch_icache_pkg::*;
#(
  parameter int unsigned  NR_PENDING = 2,
  parameter int unsigned  ID_WIDTH   = 8,
  parameter int unsigned  L0_ID      = 0,
  localparam int unsigned SW         = NR_PENDING > 1 ? $clog2(NR_PENDING) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   alloc_i,
  input  logic [SlotLineW-1:0]   alloc_line_i,
  input  logic [SlotTagW-1:0]    alloc_tag_i,
  input  logic                   rsp_valid_i,
  input  logic [ID_WIDTH-1:0]    rsp_id_i,
  output slot_t [NR_PENDING-1:0] slots_o,
  output logic                   free_o,
  output logic                   two_free_o,
  output logic [SW-1:0]          free_idx_o,
  output logic                   rsp_hit_o,
  output logic                   rsp_stale_o,
  output logic [SlotLineW-1:0]   rsp_line_o
);
  slot_t [NR_PENDING-1:0] slot_q, slot_d;
  logic  [NR_PENDING-1:0] idle, rsp_sel;
  logic  [SW-1:0]         rsp_idx;
  logic                   none_free;
  always_comb begin
    idle    = '0;
    rsp_sel = '0;
    rsp_idx = '0;
    for (int i = 0; i < NR_PENDING; i++) begin
      idle[i]    = ~slot_q[i].busy;
      rsp_sel[i] = rsp_valid_i && slot_q[i].busy &&
                   rsp_id_i == ID_WIDTH'(slot_id(L0_ID, NR_PENDING, i));
      if (rsp_sel[i]) rsp_idx = SW'(i);
    end
  end
  lzc #(.WIDTH(NR_PENDING), .MODE(1'b0)) i_free_lzc (
    .in_i   (idle),
    .cnt_o  (free_idx_o),
    .empty_o(none_free)
  );
  assign free_o      = ~none_free;
  assign two_free_o  = $countones(idle) > 1;
  assign rsp_hit_o   = |rsp_sel;
  assign rsp_stale_o = slot_q[rsp_idx].stale;
  assign rsp_line_o  = slot_q[rsp_idx].line;
  assign slots_o     = slot_q;
  // A response frees its slot before flush marks the survivors stale; a new
  // allocation never targets the responding slot since it was busy.
  always_comb begin
    slot_d = slot_q;
    if (rsp_hit_o) begin
      slot_d[rsp_idx].busy  = 1'b0;
      slot_d[rsp_idx].stale = 1'b0;
    end
    if (flush_i)
      for (int i = 0; i < NR_PENDING; i++) slot_d[i].stale = slot_d[i].busy;
    if (alloc_i)
      slot_d[free_idx_o] = '{busy: 1'b1, stale: 1'b0, line: alloc_line_i, tag: alloc_tag_i};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slot_q <= '0;
    else         slot_q <= slot_d;
  end
endmodule

// File: rtl/snitch_icache_l0_mshr.sv
// snitch_icache_l0_mshr: fully associative L0 instruction cache with
// multiple outstanding refills and next-line prefetch.
// Ports: in_* fetch interface (combinational hit, in_ready_o = hit);
// out_req_* registered line-aligned refill requests tagged with the slot ID;
// out_rsp_* refill responses, possibly out of order (always accepted);
// flush_valid_i invalidates all lines; enable_prefetching_i enables
// next-line prefetch on hits.
module snitch_icache_l0_mshr
  import snitch_icache_pkg::*;
#(
  parameter int unsigned FETCH_AW   = 48,
  parameter int unsigned FETCH_DW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned LINE_COUNT = 8,
  parameter int unsigned NR_PENDING = 2,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned L0_ID      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_valid_i,
  input  logic                  enable_prefetching_i,
  input  logic [FETCH_AW-1:0]   in_addr_i,
  input  logic                  in_valid_i,
  output logic [FETCH_DW-1:0]   in_data_o,
  output logic                  in_ready_o,
  output logic                  in_error_o,
  output logic [FETCH_AW-1:0]   out_req_addr_o,
  output logic [ID_WIDTH-1:0]   out_req_id_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
  input  logic                  out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]   out_rsp_id_i,
  input  logic                  out_rsp_valid_i,
  output logic                  out_rsp_ready_o
);
  localparam int unsigned OFF   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W = FETCH_AW - OFF;
  localparam int unsigned WORDS = LINE_WIDTH / FETCH_DW;
  localparam int unsigned WB    = $clog2(FETCH_DW / 8);
  localparam int unsigned WW    = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int unsigned LW    = $clog2(LINE_COUNT);
  localparam int unsigned SW    = NR_PENDING > 1 ? $clog2(NR_PENDING) : 1;

  logic [LINE_COUNT-1:0]                 valid_q, err_q;
  logic [LINE_COUNT-1:0][TAG_W-1:0]      tag_q;
  logic [LINE_COUNT-1:0][LINE_WIDTH-1:0] data_q;
  logic [LW-1:0]                         ptr_q, ptr_d;
  logic                                  req_valid_q, req_valid_d;
  logic [FETCH_AW-1:0]                   req_addr_q, req_addr_d;
  logic [ID_WIDTH-1:0]                   req_id_q, req_id_d;

  slot_t [NR_PENDING-1:0]    slots;
  logic                      free, two_free, rsp_hit, rsp_stale;
  logic [SW-1:0]             free_idx;
  logic [SlotLineW-1:0]      rsp_line;
  logic [NR_PENDING-1:0]     unused_stale;
  logic [TAG_W-1:0]          tag, pf_tag, alloc_tag;
  logic [LINE_COUNT-1:0]     match, pf_present, owned, avail_hi;
  logic                      hit, pend, pf_pend, miss, pf, can_alloc, alloc;
  logic [LINE_WIDTH-1:0]     hit_data;
  logic [WORDS-1:0][FETCH_DW-1:0] words;
  logic [LW-1:0]             vic, vic_hi, vic_all;
  logic                      none_hi, unused_none;

  assign tag    = in_addr_i[FETCH_AW-1:OFF];
  assign pf_tag = tag + TAG_W'(1);

  // Tag lookup, pending checks against busy slots (stale ones included, so a
  // flushed in-flight line stalls until its slot frees), and line ownership.
  always_comb begin
    match        = '0;
    pf_present   = '0;
    owned        = '0;
    hit_data     = '0;
    pend         = 1'b0;
    pf_pend      = 1'b0;
    unused_stale = '0;
    for (int j = 0; j < LINE_COUNT; j++) begin
      match[j]      = valid_q[j] && tag_q[j] == tag;
      pf_present[j] = valid_q[j] && tag_q[j] == pf_tag;
      if (match[j]) hit_data = data_q[j];
    end
    for (int i = 0; i < NR_PENDING; i++) begin
      unused_stale[i] = slots[i].stale;
      pend    = pend | (slots[i].busy && slots[i].tag == SlotTagW'(tag));
      pf_pend = pf_pend | (slots[i].busy && slots[i].tag == SlotTagW'(pf_tag));
      for (int j = 0; j < LINE_COUNT; j++)
        if (slots[i].busy && slots[i].line == SlotLineW'(j)) owned[j] = 1'b1;
    end
  end

  assign hit        = in_valid_i & |match;
  assign words      = hit_data;
  assign in_ready_o = hit;
  assign in_data_o  = words[WW'(in_addr_i[OFF-1:0] >> WB)];
  assign in_error_o = in_valid_i & |(match & err_q);

  // Prefetch keeps one slot in reserve for demand misses; a miss and a hit
  // cannot coexist, and the miss wins the tag mux regardless.
  assign miss      = in_valid_i & ~hit & ~pend;
  assign can_alloc = free & (~req_valid_q | out_req_ready_i);
  assign pf        = enable_prefetching_i & hit & ~|pf_present & ~pf_pend & two_free;
  assign alloc     = can_alloc & (miss | pf);
  assign alloc_tag = miss ? tag : pf_tag;

  // Round-robin victim: first unowned line at or above the pointer, else the
  // first unowned line overall. NR_PENDING < LINE_COUNT keeps one available.
  always_comb begin
    avail_hi = '0;
    for (int j = 0; j < LINE_COUNT; j++) avail_hi[j] = ~owned[j] && j >= int'(ptr_q);
  end
  lzc #(.WIDTH(LINE_COUNT), .MODE(1'b0)) i_vic_hi_lzc (
    .in_i   (avail_hi),
    .cnt_o  (vic_hi),
    .empty_o(none_hi)
  );
  lzc #(.WIDTH(LINE_COUNT), .MODE(1'b0)) i_vic_all_lzc (
    .in_i   (~owned),
    .cnt_o  (vic_all),
    .empty_o(unused_none)
  );
  assign vic   = none_hi ? vic_all : vic_hi;
  assign ptr_d = alloc ? (vic == LW'(LINE_COUNT - 1) ? '0 : vic + LW'(1)) : ptr_q;

  always_comb begin
    req_valid_d = req_valid_q & ~out_req_ready_i;
    req_addr_d  = req_addr_q;
    req_id_d    = req_id_q;
    if (alloc) begin
      req_valid_d = 1'b1;
      req_addr_d  = {alloc_tag, {OFF{1'b0}}};
      req_id_d    = ID_WIDTH'(slot_id(L0_ID, NR_PENDING, int'(free_idx)));
    end
  end

  snitch_icache_l0_mshr_slots #(
    .NR_PENDING(NR_PENDING),
    .ID_WIDTH  (ID_WIDTH),
    .L0_ID     (L0_ID)
  ) i_slots (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_valid_i),
    .alloc_i     (alloc),
    .alloc_line_i(SlotLineW'(vic)),
    .alloc_tag_i (SlotTagW'(alloc_tag)),
    .rsp_valid_i (out_rsp_valid_i),
    .rsp_id_i    (out_rsp_id_i),
    .slots_o     (slots),
    .free_o      (free),
    .two_free_o  (two_free),
    .free_idx_o  (free_idx),
    .rsp_hit_o   (rsp_hit),
    .rsp_stale_o (rsp_stale),
    .rsp_line_o  (rsp_line)
  );

  // Flush is applied last so it wins over a same-cycle refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      err_q       <= '0;
      ptr_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_id_q    <= req_id_d;
      for (int j = 0; j < LINE_COUNT; j++) begin
        if (rsp_hit && !rsp_stale && rsp_line == SlotLineW'(j)) begin
          valid_q[j] <= 1'b1;
          err_q[j]   <= out_rsp_error_i;
        end
        if (alloc && vic == LW'(j)) valid_q[j] <= 1'b0;
        if (flush_valid_i) valid_q[j] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < LINE_COUNT; j++) begin
      if (rsp_hit && rsp_line == SlotLineW'(j)) data_q[j] <= out_rsp_data_i;
      if (alloc && vic == LW'(j)) tag_q[j] <= alloc_tag;
    end
  end

  assign out_req_valid_o = req_valid_q;
  assign out_req_addr_o  = req_addr_q;
  assign out_req_id_o    = req_id_q;
  assign out_rsp_ready_o = 1'b1;
endmodule

// File: tb/tb_snitch_icache_l0_mshr.sv
// tb_snitch_icache_l0_mshr: directed self-checking bench for the L0 MSHR.
// Line data for base address A holds word k = 0xD0000000 | (A + 4k), so a
// hit at fetch address X returns 0xD0000000 | X.
module tb_snitch_icache_l0_mshr;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, pf_en;
  logic [47:0]  in_addr;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready, in_error;
  logic [47:0]  req_addr;
  logic [7:0]   req_id;
  logic         req_valid, req_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [7:0]   rsp_id;
  logic         rsp_valid, rsp_ready;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  snitch_icache_l0_mshr dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_valid_i       (flush),
    .enable_prefetching_i(pf_en),
    .in_addr_i           (in_addr),
    .in_valid_i          (in_valid),
    .in_data_o           (in_data),
    .in_ready_o          (in_ready),
    .in_error_o          (in_error),
    .out_req_addr_o      (req_addr),
    .out_req_id_o        (req_id),
    .out_req_valid_o     (req_valid),
    .out_req_ready_i     (req_ready),
    .out_rsp_data_i      (rsp_data),
    .out_rsp_error_i     (rsp_err),
    .out_rsp_id_i        (rsp_id),
    .out_rsp_valid_i     (rsp_valid),
    .out_rsp_ready_o     (rsp_ready)
  );

  function automatic logic [127:0] mkline(input logic [47:0] base);
    logic [31:0] b;
    b = 32'hD000_0000 | base[31:0];
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; pf_en = 1'b0; in_addr = '0; in_valid = 1'b0;
    req_ready = 1'b1; rsp_data = '0; rsp_err = 1'b0; rsp_id = '0; rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic respond(input logic [7:0] id, input logic [47:0] base, input logic err);
    rsp_valid = 1'b1; rsp_id = id; rsp_data = mkline(base); rsp_err = err;
    tick();
    rsp_valid = 1'b0; rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; pf_en = 1'b1; in_addr = 48'h1000; in_valid = 1'b1;
    req_ready = 1'b1; rsp_data = '0; rsp_err = 1'b0; rsp_id = '0; rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_chk++; if (in_error !== 1'b0) begin n_fail++; $display("FAIL reset_in_error: got %b expected 0", in_error); end
    n_chk++; if (in_data !== 32'h0) begin n_fail++; $display("FAIL reset_in_data: got %h expected 0", in_data); end
    n_chk++; if (rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_ready: got %b expected 1", rsp_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    in_addr = 48'h1000; in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_miss_ready: got %b expected 0", in_ready); end
    tick();
    n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_req_valid: got %b expected 1", req_valid); end
    n_chk++; if (req_addr !== 48'h1000) begin n_fail++; $display("FAIL basic_req_addr: got %h expected 1000", req_addr); end
    n_chk++; if (req_id !== 8'd0) begin n_fail++; $display("FAIL basic_req_id: got %0d expected 0", req_id); end
    respond(8'd1, 48'h1000, 1'b0);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_idle_id_ignored: got %b expected 0", in_ready); end
    respond(8'd0, 48'h1000, 1'b0);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %b expected 1", in_ready); end
    n_chk++; if (in_data !== 32'hD000_1000) begin n_fail++; $display("FAIL basic_word0: got %h expected d0001000", in_data); end
    in_addr = 48'h100C;
    #1;
    n_chk++; if (in_data !== 32'hD000_100C) begin n_fail++; $display("FAIL basic_word3: got %h expected d000100c", in_data); end
    n_chk++; if (in_error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b expected 0", in_error); end
    in_valid = 1'b0;
  endtask

  task automatic test_out_of_order();
    do_reset();
    in_addr = 48'h1000; in_valid = 1'b1;
    tick();
    n_chk++; if (req_addr !== 48'h1000) begin n_fail++; $display("FAIL ooo_req0_addr: got %h expected 1000", req_addr); end
    in_addr = 48'h2000;
    tick();
    n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_req1_valid: got %b expected 1", req_valid); end
    n_chk++; if (req_addr !== 48'h2000) begin n_fail++; $display("FAIL ooo_req1_addr: got %h expected 2000", req_addr); end
    n_chk++; if (req_id !== 8'd1) begin n_fail++; $display("FAIL ooo_req1_id: got %0d expected 1", req_id); end
    in_valid = 1'b0;
    respond(8'd1, 48'h2000, 1'b0);
    respond(8'd0, 48'h1000, 1'b0);
    in_addr = 48'h2008; in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_hit_2000: got %b expected 1", in_ready); end
    n_chk++; if (in_data !== 32'hD000_2008) begin n_fail++; $display("FAIL ooo_data_2008: got %h expected d0002008", in_data); end
    in_addr = 48'h1004;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ooo_hit_1000: got %b expected 1", in_ready); end
    n_chk++; if (in_data !== 32'hD000_1004) begin n_fail++; $display("FAIL ooo_data_1004: got %h expected d0001004", in_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_prefetch();
    do_reset();
    in_addr = 48'h1000; in_valid = 1'b1;
    tick();
    respond(8'd0, 48'h1000, 1'b0);
    pf_en = 1'b1;
    #1;
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL pf_idle_before: got %b expected 0", req_valid); end
    tick();
    n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL pf_req_valid: got %b expected 1", req_valid); end
    n_chk++; if (req_addr !== 48'h1010) begin n_fail++; $display("FAIL pf_req_addr: got %h expected 1010", req_addr); end
    n_chk++; if (req_id !== 8'd0) begin n_fail++; $display("FAIL pf_req_id: got %0d expected 0", req_id); end
    in_addr = 48'h1004;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pf_second_hit: got %b expected 1", in_ready); end
    tick();
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL pf_no_duplicate: got %b expected 0", req_valid); end
    in_valid = 1'b0; pf_en = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    in_addr = 48'h3000; in_valid = 1'b1;
    tick();
    n_chk++; if (req_addr !== 48'h3000) begin n_fail++; $display("FAIL flush_req_addr: got %h expected 3000", req_addr); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    respond(8'd0, 48'h3000, 1'b0);
    in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_line_invalid: got %b expected 0", in_ready); end
    tick();
    n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_refetch_valid: got %b expected 1", req_valid); end
    n_chk++; if (req_addr !== 48'h3000) begin n_fail++; $display("FAIL flush_refetch_addr: got %h expected 3000", req_addr); end
    n_chk++; if (req_id !== 8'd0) begin n_fail++; $display("FAIL flush_refetch_id: got %0d expected 0", req_id); end
    in_valid = 1'b0; flush = 1'b1;
    respond(8'd0, 48'h3000, 1'b0);
    flush = 1'b0; in_valid = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_beats_rsp: got %b expected 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_error();
    do_reset();
    in_addr = 48'h4000; in_valid = 1'b1;
    tick();
    respond(8'd0, 48'h4000, 1'b1);
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL err_hit: got %b expected 1", in_ready); end
    n_chk++; if (in_error !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", in_error); end
    n_chk++; if (in_data !== 32'hD000_4000) begin n_fail++; $display("FAIL err_data: got %h expected d0004000", in_data); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_ready = 1'b0; in_addr = 48'h5000; in_valid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, req_valid); end
      n_chk++; if (req_addr !== 48'h5000) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected 5000", k, req_addr); end
      n_chk++; if (req_id !== 8'd0) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d expected 0", k, req_id); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
      if (k < 4) tick();
    end
    req_ready = 1'b1;
    tick();
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handoff: got %b expected 0", req_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_all_busy();
    do_reset();
    in_addr = 48'h6000; in_valid = 1'b1;
    tick();
    in_addr = 48'h7000;
    tick();
    n_chk++; if (req_addr !== 48'h7000) begin n_fail++; $display("FAIL busy_req1_addr: got %h expected 7000", req_addr); end
    n_chk++; if (req_id !== 8'd1) begin n_fail++; $display("FAIL busy_req1_id: got %0d expected 1", req_id); end
    in_addr = 48'h8000;
    tick();
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL busy_stall_req: got %b expected 0", req_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_stall_ready: got %b expected 0", in_ready); end
    respond(8'd0, 48'h6000, 1'b0);
    n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL busy_no_alloc_on_rsp: got %b expected 0", req_valid); end
    tick();
    n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL busy_resume_valid: got %b expected 1", req_valid); end
    n_chk++; if (req_addr !== 48'h8000) begin n_fail++; $display("FAIL busy_resume_addr: got %h expected 8000", req_addr); end
    n_chk++; if (req_id !== 8'd0) begin n_fail++; $display("FAIL busy_resume_id: got %0d expected 0", req_id); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_prefetch();
    test_flush();
    test_error();
    test_backpressure();
    test_all_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
